// File: rtl/riscvsys_evcnt_pkg.sv
// riscvsys_evcnt_pkg: register map offsets and CTRL bit positions for the event counter bank
package riscvsys_evcnt_pkg;
   localparam logic [8:0] OFF_CTRL      = 9'h000;
   localparam logic [8:0] OFF_NEV       = 9'h004;
   localparam logic [8:0] OFF_OVF       = 9'h008;
   localparam logic [8:0] OFF_SNAP_BASE = 9'h100;
   localparam int CTRL_EN   = 0;
   localparam int CTRL_CLR  = 1;
   localparam int CTRL_SNAP = 2;
   localparam int WIN_BYTES = 512;
endpackage

// File: rtl/riscvsys_evcnt_ctr.sv
// riscvsys_evcnt_ctr: one saturating event counter with enable and synchronous clear
module riscvsys_evcnt_ctr #(
   parameter int CNT_W = 32
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_en,
   input  logic             i_inc,
   input  logic             i_clr,
   output logic [CNT_W-1:0] o_cnt,
   output logic             o_sat
);
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             full;
   assign full  = &cnt_q;
   assign o_cnt = cnt_q;
   // an event arriving at all-ones is dropped and flagged; clear beats the event
   assign o_sat = i_en & i_inc & full & ~i_clr;
   // next count: clear first, otherwise increment unless already saturated
   always_comb begin
      cnt_d = i_clr ? '0 : (i_en & i_inc & ~full) ? cnt_q + CNT_W'(1) : cnt_q;
   end
   // counter register
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) cnt_q <= '0;
      else cnt_q <= cnt_d;
   end
endmodule

// File: rtl/riscvsys_evcnt.sv
// riscvsys_evcnt: bus-mapped bank of saturating event counters with coherent snapshots
module riscvsys_evcnt
   import riscvsys_evcnt_pkg::*;
#(
   parameter int          N_EV  = 16,
   parameter int          CNT_W = 32,
   parameter logic [31:0] BASE  = 32'h3000_0000
) (
   input  logic            i_clk,
   input  logic            i_rst,
   input  logic [N_EV-1:0] i_ev,
   input  logic            i_valid,
   input  logic [31:0]     i_addr,
   input  logic [31:0]     i_wdata,
   input  logic [3:0]      i_wstrb,
   output logic            o_hit,
   output logic            o_ready,
   output logic [31:0]     o_rdata
);
   logic [CNT_W-1:0] cnt [N_EV];
   logic [CNT_W-1:0] snap_q [N_EV];
   logic [N_EV-1:0]  sat, ovf_q, ovf_d;
   logic             ready_q, ready_d, en_q, en_d;
   logic [31:0]      rdata_q, rdata_d, rd_val, rd_snap;
   logic [8:0]       off;
   logic             wr_ctrl, clr, snap;
   logic             unused;
   assign unused  = ^{i_addr[1:0], i_wdata[31:3]};
   assign o_hit   = (i_addr - BASE) < 32'(WIN_BYTES);
   assign off     = {i_addr[8:2], 2'b00};
   // CTRL writes commit on the acknowledge cycle, when the master still holds the request
   assign wr_ctrl = i_valid & o_hit & ready_q & (|i_wstrb) & (off == OFF_CTRL);
   assign clr     = wr_ctrl & i_wdata[CTRL_CLR];
   assign snap    = wr_ctrl & i_wdata[CTRL_SNAP];
   assign o_ready = ready_q;
   assign o_rdata = rdata_q;
   for (genvar g = 0; g < N_EV; g++) begin : g_ctr
      riscvsys_evcnt_ctr #(.CNT_W(CNT_W)) u_ctr (
         .i_clk (i_clk),
         .i_rst (i_rst),
         .i_en  (en_q),
         .i_inc (i_ev[g]),
         .i_clr (clr),
         .o_cnt (cnt[g]),
         .o_sat (sat[g])
      );
   end
   // read mux: only snapshots are visible, so multi-counter readouts stay coherent
   always_comb begin
      rd_snap = '0;
      for (int k = 0; k < N_EV; k++)
         if (off == OFF_SNAP_BASE + 9'(4 * k)) rd_snap = 32'(snap_q[k]);
      rd_val = off == OFF_CTRL ? 32'(en_q) :
               off == OFF_NEV  ? 32'(N_EV) :
               off == OFF_OVF  ? 32'(ovf_q) : rd_snap;
   end
   // next state for ack, read data, enable and sticky overflow
   always_comb begin
      ready_d = i_valid & o_hit & ~ready_q;
      rdata_d = ready_d ? rd_val : '0;
      en_d    = wr_ctrl ? i_wdata[CTRL_EN] : en_q;
      ovf_d   = clr ? '0 : ovf_q | sat;
   end
   // control and bus response registers
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         ready_q <= 1'b0;
         rdata_q <= '0;
         en_q    <= 1'b0;
         ovf_q   <= '0;
      end else begin
         ready_q <= ready_d;
         rdata_q <= rdata_d;
         en_q    <= en_d;
         ovf_q   <= ovf_d;
      end
   end
   // snapshot array captures pre-increment counts at the committing edge
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         for (int k = 0; k < N_EV; k++) snap_q[k] <= '0;
      end else if (snap) begin
         for (int k = 0; k < N_EV; k++) snap_q[k] <= cnt[k];
      end
   end
endmodule

// File: tb/tb_riscvsys_evcnt.sv
// tb_riscvsys_evcnt: scoreboard bench with a transaction-level counter model
module tb_riscvsys_evcnt;
   localparam int          N    = 16;
   localparam int          W    = 4;
   localparam int          MAX  = (1 << W) - 1;
   localparam logic [31:0] BASE = 32'h3000_0000;

   logic        clk = 1'b0, rst = 1'b1, valid = 1'b0;
   logic [15:0] ev = '0;
   logic [31:0] addr = '0, wdata = '0;
   logic [3:0]  wstrb = '0;
   logic        hit, ready;
   logic [31:0] rdata;

   riscvsys_evcnt #(.N_EV(N), .CNT_W(W), .BASE(BASE)) dut (
      .i_clk   (clk),
      .i_rst   (rst),
      .i_ev    (ev),
      .i_valid (valid),
      .i_addr  (addr),
      .i_wdata (wdata),
      .i_wstrb (wstrb),
      .o_hit   (hit),
      .o_ready (ready),
      .o_rdata (rdata)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int          due;
      logic [31:0] data;
      string       name;
   } exp_t;
   exp_t q[$];
   int   pass_n = 0, tot_n = 0;
   bit   mon_on = 0;

   // reference model: counts, snapshots, overflow flags and enable
   int unsigned mc[N], ms[N];
   logic [15:0] movf;
   bit          men;

   task automatic chk(string nm, logic [31:0] act, logic [31:0] want);
      tot_n++;
      if (act === want) pass_n++;
      else $display("FAIL %s: got %h want %h", nm, act, want);
   endtask

   task automatic mreset();
      for (int i = 0; i < N; i++) begin mc[i] = 0; ms[i] = 0; end
      movf = '0;
      men  = 0;
   endtask

   task automatic mstep(logic [15:0] e, bit wr, logic [31:0] wd);
      if (wr && wd[2]) for (int i = 0; i < N; i++) ms[i] = mc[i];
      if (wr && wd[1]) begin
         for (int i = 0; i < N; i++) mc[i] = 0;
         movf = '0;
      end else if (men) begin
         for (int i = 0; i < N; i++)
            if (e[i]) begin
               if (mc[i] == MAX) movf[i] = 1'b1;
               else mc[i]++;
            end
      end
      if (wr) men = wd[0];
   endtask

   function automatic logic [31:0] mread(logic [31:0] a);
      logic [31:0] o;
      o = (a - BASE) & 32'h1FC;
      if (o == 0) return {31'b0, men};
      if (o == 4) return N;
      if (o == 8) return {16'b0, movf};
      if (o >= 32'h100 && o < 32'h100 + 4 * N) return ms[(o - 32'h100) >> 2];
      return 0;
   endfunction

   task automatic tick(bit wr);
      @(posedge clk);
      if (!rst) mstep(ev, wr, wdata);
      #1;
   endtask

   task automatic idle(logic [15:0] e, int n);
      repeat (n) begin ev = e; tick(0); end
      ev = '0;
   endtask

   // one request: valid cycle then ack cycle; want < 0 means take the model's value
   task automatic access(string nm, logic [31:0] a, logic [31:0] wd, logic [3:0] ws,
                         logic [15:0] e0, logic [15:0] e1, int want = -1);
      bit   h;
      exp_t x;
      h = (a - BASE) < 32'h200;
      valid = 1'b1; addr = a; wdata = wd; wstrb = ws; ev = e0;
      #1;
      chk({nm, " hit"}, 32'(hit), 32'(h));
      if (h) begin
         x.due = cyc + 1;
         x.data = want < 0 ? mread(a) : want;
         x.name = nm;
         q.push_back(x);
      end
      tick(0);
      ev = e1;
      tick(h && ws != 0 && ((a - BASE) & 32'h1FC) == 0);
      valid = 1'b0; wstrb = '0; ev = '0;
   endtask

   // monitor: an ack is required exactly on the due cycle and forbidden otherwise
   always @(negedge clk) begin
      if (mon_on) begin
         if (q.size() != 0 && q[0].due == cyc) begin
            chk({q[0].name, " ack"}, 32'(ready), 32'd1);
            chk(q[0].name, rdata, q[0].data);
            void'(q.pop_front());
         end else begin
            chk("no_ack", 32'(ready), 32'd0);
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1);
   end

   initial begin
      int r;
      logic [15:0] e;
      mreset();
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      mon_on = 1;
      // reset values
      access("ctrl_rst", BASE, 0, 0, 0, 0, 0);
      access("nev", BASE + 4, 0, 0, 0, 0, 16);
      access("ovf_rst", BASE + 8, 0, 0, 0, 0, 0);
      access("snap0_rst", BASE + 32'h100, 0, 0, 0, 0, 0);
      // five pulses on event 3
      access("en_wr", BASE, 1, 4'hF, 0, 0, 0);
      idle(16'h0008, 5);
      access("snap_wr", BASE, 5, 4'hF, 0, 0, 1);
      access("snap3", BASE + 32'h10C, 0, 0, 0, 0, 5);
      access("snap0_zero", BASE + 32'h100, 0, 0, 0, 0, 0);
      // saturation and clear
      idle(16'h0001, 20);
      access("snap_wr2", BASE, 5, 4'hF, 0, 0, 1);
      access("snap0_sat", BASE + 32'h100, 0, 0, 0, 0, 15);
      access("ovf_sat", BASE + 8, 0, 0, 0, 0, 1);
      access("clr_wr", BASE, 3, 4'hF, 0, 0, 1);
      access("snap_wr3", BASE, 5, 4'hF, 0, 0, 1);
      access("snap0_clr", BASE + 32'h100, 0, 0, 0, 0, 0);
      access("ovf_clr", BASE + 8, 0, 0, 0, 0, 0);
      // SNAP and CLR together with event 2 held
      access("clrsnap_wr", BASE, 7, 4'hF, 16'h4, 16'h4, 1);
      access("snap2_pre", BASE + 32'h108, 0, 0, 16'h4, 0, 1);
      access("snap_wr4", BASE, 5, 4'hF, 0, 0, 1);
      access("snap2_after", BASE + 32'h108, 0, 0, 0, 0, 1);
      // out-of-window and read-only writes
      idle(16'h0001, 17);
      access("ovf_ro_wr", BASE + 8, 0, 4'hF, 0, 0, 1);
      access("oow_top", BASE + 32'h200, 2, 4'hF, 0, 0);
      access("oow_tb", 32'h2000_0000, 2, 4'hF, 0, 0);
      access("ovf_kept", BASE + 8, 0, 0, 0, 0, 1);
      access("snap_wr5", BASE, 5, 4'hF, 0, 0, 1);
      access("snap0_kept", BASE + 32'h100, 0, 0, 0, 0, 15);
      // reset while the ack is on the bus
      valid = 1'b1; addr = BASE + 4; wdata = 0; wstrb = 0;
      tick(0);
      chk("pre_rst_ack", 32'(ready), 32'd1);
      chk("pre_rst_rdata", rdata, 32'd16);
      rst = 1'b1; mreset();
      #1;
      chk("rst_ack", 32'(ready), 32'd0);
      chk("rst_rdata", rdata, 32'd0);
      valid = 1'b0;
      tick(0);
      rst = 1'b0;
      // reset between valid and ready abandons the request
      access("en_wr2", BASE, 1, 4'hF, 0, 0, 0);
      idle(16'hFFFF, 3);
      valid = 1'b1; addr = BASE + 4; wstrb = 0;
      #2;
      rst = 1'b1; q.delete(); mreset();
      #1;
      chk("rst_mid_ack", 32'(ready), 32'd0);
      tick(0);
      valid = 1'b0;
      rst = 1'b0;
      tick(0);
      access("ctrl_post_rst", BASE, 0, 0, 0, 0, 0);
      access("snap_only_wr", BASE, 4, 4'hF, 0, 0, 0);
      access("snap1_post_rst", BASE + 32'h104, 0, 0, 0, 0, 0);
      access("ovf_post_rst", BASE + 8, 0, 0, 0, 0, 0);
      // randomized traffic against the model
      repeat (300) begin
         r = $urandom_range(0, 9);
         e = 16'($urandom & $urandom);
         case (r)
            0, 1: idle(e, $urandom_range(1, 4));
            2: access("rnd_ctrl_wr", BASE, $urandom_range(0, 7) | 1, 4'($urandom_range(1, 15)), e, 16'($urandom));
            3: access("rnd_ctrl", BASE, 0, 0, e, e);
            4: access("rnd_nev", BASE + 4, 0, 0, e, e);
            5: access("rnd_ovf", BASE + 8, 0, 0, e, e);
            6, 7: access("rnd_snap", BASE + 32'h100 + 4 * $urandom_range(0, 31), 0, 0, e, e);
            8: access("rnd_win", BASE + $urandom_range(0, 511), $urandom, 4'($urandom_range(0, 15)), e, e);
            default: access("rnd_oow", $urandom_range(0, 1) ? BASE + 32'h200 + $urandom_range(0, 4095) : BASE - 1 - $urandom_range(0, 4095), 6, 4'hF, e, e);
         endcase
      end
      idle(0, 3);
      chk("drain", q.size(), 0);
      $display("%0d/%0d checks passed", pass_n, tot_n);
      $finish;
   end
endmodule
